// File: rtl/lcd_bucle_espera.sv
// lcd_bucle_espera: HD44780 8-bit driver; init, CGRAM glyph load, face/icon draw, redraw on input change (optional sleep view: SLEEP_VIEW_EN)
module lcd_bucle_espera #(
  parameter int COUNT_MAX = 100000,
  parameter int FACE_COL  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] select_figures,
  input  logic [1:0] sleep,
  output logic       rs,
  output logic       rw,
  output logic       enable,
  output logic [7:0] data
);
  typedef enum logic [2:0] {POWER_WAIT, INIT, CGRAM, LINE1, LINE2, WAIT} state_t;
  localparam int CW = $clog2(COUNT_MAX);
  localparam logic [CW-1:0] CLAST = CW'(COUNT_MAX - 1);
  localparam logic [CW-1:0] HALF = CW'(COUNT_MAX / 2);
  localparam logic [3:0] FC = 4'(FACE_COL);
  localparam logic [7:0] INIT_CMD [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  localparam logic [7:0] GLYPH [64] = '{
    8'h00, 8'h0A, 8'h0A, 8'h00, 8'h11, 8'h0E, 8'h00, 8'h00,
    8'h00, 8'h0A, 8'h0A, 8'h00, 8'h0E, 8'h11, 8'h00, 8'h00,
    8'h00, 8'h0A, 8'h0A, 8'h00, 8'h0E, 8'h0E, 8'h0E, 8'h00,
    8'h00, 8'h11, 8'h0A, 8'h11, 8'h00, 8'h0E, 8'h15, 8'h00,
    8'h02, 8'h04, 8'h08, 8'h1F, 8'h02, 8'h04, 8'h08, 8'h00,
    8'h04, 8'h0E, 8'h1F, 8'h1F, 8'h0E, 8'h04, 8'h0E, 8'h00,
    8'h00, 8'h0A, 8'h1F, 8'h1F, 8'h0E, 8'h04, 8'h00, 8'h00,
    8'h0E, 8'h11, 8'h15, 8'h11, 8'h0E, 8'h04, 8'h0A, 8'h11
  };
  state_t state_q, state_d, ns;
  logic [6:0] idx_q, idx_d, ni;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rs_q, rs_d, en_q, en_d, nrs, go, diff, sleepy;
  logic [7:0] data_q, data_d, ndata;
  logic [3:0] sel_q, sel_d, col;
`ifdef SLEEP_VIEW_EN
  logic [1:0] slp_q, slp_d;
  assign sleepy = slp_q == 2'b11;
  assign diff = (select_figures != sel_q) || (sleep != slp_q);
`else
  logic unused_sleep;
  assign unused_sleep = ^sleep;
  assign sleepy = 1'b0;
  assign diff = select_figures != sel_q;
`endif
  // step that follows the current one
  always_comb begin
    ns = state_q;
    ni = idx_q + 7'd1;
    case (state_q)
      POWER_WAIT: begin ns = INIT; ni = '0; end
      INIT: if (idx_q == 7'd3) begin ns = CGRAM; ni = '0; end
      CGRAM: if (idx_q == 7'd64) begin ns = LINE1; ni = '0; end
      LINE1: if (idx_q == 7'd16) begin ns = LINE2; ni = '0; end
      LINE2: if (idx_q == 7'd16) begin ns = WAIT; ni = '0; end
      default: begin ns = LINE1; ni = '0; end
    endcase
  end
  // bus contents for that step; index 0 of each group is the command byte
  always_comb begin
    col = 4'(ni - 7'd1);
    nrs = ni != '0;
    ndata = 8'h20;
    case (ns)
      INIT: begin nrs = 1'b0; ndata = INIT_CMD[ni[1:0]]; end
      CGRAM: ndata = ni == '0 ? 8'h40 : GLYPH[6'(ni - 7'd1)];
      LINE1: ndata = ni == '0 ? 8'h80 : col != FC ? 8'h20 : sleepy ? 8'h7A : {6'b0, sel_q[3:2]};
      LINE2: ndata = ni == '0 ? 8'hC0 : col != FC || sleepy ? 8'h20 : 8'h04 + {6'b0, sel_q[1:0]};
      default: begin nrs = rs_q; ndata = data_q; end
    endcase
  end
  always_comb begin
    go = state_q == WAIT ? diff : cnt_q == CLAST;
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    rs_d = rs_q;
    data_d = data_q;
    en_d = 1'b0;
    sel_d = sel_q;
`ifdef SLEEP_VIEW_EN
    slp_d = slp_q;
`endif
    if (go) begin
      state_d = ns;
      idx_d = ni;
      cnt_d = '0;
      rs_d = nrs;
      data_d = ndata;
      en_d = ns != WAIT;
      if (ns == LINE1 && ni == '0) begin
        sel_d = select_figures;
`ifdef SLEEP_VIEW_EN
        slp_d = sleep;
`endif
      end
    end else begin
      cnt_d = state_q == WAIT ? '0 : cnt_q + CW'(1);
      en_d = en_q && (cnt_q + CW'(1) < HALF);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= POWER_WAIT;
      idx_q <= '0;
      cnt_q <= '0;
      rs_q <= 1'b0;
      data_q <= 8'h00;
      en_q <= 1'b0;
      sel_q <= '0;
`ifdef SLEEP_VIEW_EN
      slp_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      rs_q <= rs_d;
      data_q <= data_d;
      en_q <= en_d;
      sel_q <= sel_d;
`ifdef SLEEP_VIEW_EN
      slp_q <= slp_d;
`endif
    end
  end
  assign rs = rs_q;
  assign rw = 1'b0;
  assign enable = en_q;
  assign data = data_q;
endmodule

// File: tb/tb_lcd_bucle_espera.sv
// tb_lcd_bucle_espera: table-driven check of the LCD command/data stream per enable pulse
module tb_lcd_bucle_espera;
  localparam int CM = 100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] sel = 4'b1000;
  logic [1:0] slp = 2'b00;
  logic rs, rw, enable;
  logic [7:0] data;
  always #5 clk = ~clk;
  lcd_bucle_espera #(.COUNT_MAX(CM), .FACE_COL(7)) dut (
    .clk(clk), .reset(reset), .select_figures(sel), .sleep(slp),
    .rs(rs), .rw(rw), .enable(enable), .data(data)
  );
  typedef struct {logic rs; logic [7:0] d; bit any;} vec_t;
  vec_t tbl[$];
  logic [9:0] q[$];
  logic [7:0] g [64];
  int nvec = 0, nbad = 0, hi = 0, last_w = 0;
  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (enable && !en_prev) q.push_back({rw, rs, data});
    if (enable) hi = en_prev ? hi + 1 : 1;
    else if (en_prev) last_w = hi;
    en_prev = enable;
  end
  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_q(input int n, input int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin @(negedge clk); c++; end
    check("pulse_count", q.size(), n);
  endtask
  task automatic quiet(input int cycles);
    repeat (cycles) @(negedge clk);
    check("no_pulses", q.size(), 0);
  endtask
  task automatic add(input logic r, input logic [7:0] d, input bit any);
    vec_t v;
    v.rs = r; v.d = d; v.any = any;
    tbl.push_back(v);
  endtask
  task automatic add_line(input logic [7:0] cmd, input logic [7:0] fb);
    add(1'b0, cmd, 1'b0);
    for (int c = 0; c < 16; c++) add(1'b1, c == 7 ? fb : 8'h20, 1'b0);
  endtask
  task automatic run_table(input string name);
    logic [9:0] x;
    for (int i = 0; i < tbl.size(); i++) begin
      nvec++;
      if (q.size() == 0) begin
        nbad++;
        $display("FAIL %s[%0d]: no pulse, expected rs=%0b data=%02h", name, i, tbl[i].rs, tbl[i].d);
      end else begin
        x = q.pop_front();
        if (x[9] !== 1'b0 || x[8] !== tbl[i].rs || (tbl[i].any ? x[7:5] !== 3'b000 : x[7:0] !== tbl[i].d)) begin
          nbad++;
          $display("FAIL %s[%0d]: got rw=%0b rs=%0b data=%02h expected rw=0 rs=%0b data=%02h%s",
                   name, i, x[9], x[8], x[7:0], tbl[i].rs, tbl[i].d, tbl[i].any ? " (any glyph row)" : "");
        end
      end
    end
    tbl.delete();
  endtask
  initial begin
    int dup;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs", {rs, rw, enable, data}, 0);
    end
    reset = 1'b0;
    quiet(90);
    wait_q(103, 12000);
    for (int i = 0; i < 64; i++) g[i] = (q.size() > 5 + i) ? q[5 + i][7:0] : 8'h00;
    add(1'b0, 8'h38, 1'b0); add(1'b0, 8'h0C, 1'b0); add(1'b0, 8'h01, 1'b0); add(1'b0, 8'h06, 1'b0);
    add(1'b0, 8'h40, 1'b0);
    for (int i = 0; i < 64; i++) add(1'b1, 8'h00, 1'b1);
    add_line(8'h80, 8'h02);
    add_line(8'hC0, 8'h04);
    run_table("boot");
    for (int k = 0; k < 8; k++)
      check("glyph_nonzero", ({g[8*k], g[8*k+1], g[8*k+2], g[8*k+3], g[8*k+4], g[8*k+5], g[8*k+6], g[8*k+7]} != 64'h0) ? 1 : 0, 1);
    dup = 0;
    for (int a = 0; a < 8; a++)
      for (int b = a + 1; b < 8; b++)
        if ({g[8*a], g[8*a+1], g[8*a+2], g[8*a+3], g[8*a+4], g[8*a+5], g[8*a+6], g[8*a+7]} ==
            {g[8*b], g[8*b+1], g[8*b+2], g[8*b+3], g[8*b+4], g[8*b+5], g[8*b+6], g[8*b+7]}) dup++;
    check("glyph_distinct_dups", dup, 0);
    check("enable_width", last_w, CM / 2);
    quiet(10 * CM);
    sel = 4'b0101;
    wait_q(34, 4000);
    add_line(8'h80, 8'h01);
    add_line(8'hC0, 8'h05);
    run_table("redraw");
    quiet(10 * CM);
    slp = 2'b11;
`ifdef SLEEP_VIEW_EN
    wait_q(34, 4000);
    add_line(8'h80, 8'h7A);
    add_line(8'hC0, 8'h20);
    run_table("sleep");
    quiet(10 * CM);
`else
    quiet(40 * CM);
`endif
    sel = 4'b1100;
    wait_q(5, 1000);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {rs, rw, enable, data}, 0);
    repeat (2) @(negedge clk);
    q.delete();
    reset = 1'b0;
    quiet(90);
    wait_q(5, 1000);
    add(1'b0, 8'h38, 1'b0); add(1'b0, 8'h0C, 1'b0); add(1'b0, 8'h01, 1'b0); add(1'b0, 8'h06, 1'b0);
    add(1'b0, 8'h40, 1'b0);
    run_table("restart");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/lcd_bucle_espera.md
Name: lcd_bucle_espera

Overview:
- Drives a 16x2 HD44780-compatible character LCD over an 8-bit parallel bus for the pet display.
- After reset it initialises the LCD, loads 8 custom glyphs into CGRAM, then draws a face glyph on line 1 and a status icon on line 2.
- It then stays in a wait loop and redraws both lines whenever the figure selection or sleep input changes.
- Sits between the game-state logic (select_figures, sleep) and the LCD pins.

Parameters:
- COUNT_MAX, 100000: clock cycles per bus step (one command or data byte). Must cover the slowest command (clear, 1.6 ms).
- FACE_COL, 7: column (0-15) where the face glyph or icon glyph is written on each line.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- select_figures  in  4  [3:2] face index 0-3 (0 happy, 1 sad, 2 hungry, 3 sick); [1:0] icon index 0-3 (0 energy, 1 food, 2 heart, 3 play).
- sleep  in  2  2'b11 = sleeping view; any other value = normal view.
- rs  out  1  LCD register select: 0 = command, 1 = data.
- rw  out  1  LCD read/write; always 0 (write only).
- enable  out  1  LCD E strobe.
- data  out  8  LCD DB7..DB0.

Behaviour:
- Reset (sync, active-high):
  - rs=0, rw=0, enable=0, data=8'h00.
  - Step counter cleared; FSM returns to POWER_WAIT.
  - Reset asserted mid-sequence aborts the sequence and restarts it from POWER_WAIT.
- Step timing:
  - A step lasts COUNT_MAX cycles.
  - rs and data are updated on the first cycle of the step and held for the whole step.
  - enable=1 for cycles 0..COUNT_MAX/2-1 of the step, then 0; the LCD latches on the falling edge.
- FSM states:
  - POWER_WAIT: one idle step with enable=0, then go to INIT.
  - INIT: commands with rs=0, in order 8'h38, 8'h0C, 8'h01, 8'h06.
  - CGRAM: command 8'h40, then 64 data bytes with rs=1. Glyph g, row r (0-7) is sent as byte 8*g+r.
  - LINE1: command 8'h80, then 16 data bytes.
  - LINE2: command 8'hC0, then 16 data bytes.
  - WAIT: enable=0, data and rs hold their last values.
- Glyph table (constant ROM; bits [7:5]=0, 5-pixel rows in [4:0]):
  - Glyphs 0-3 are the faces in face-index order.
  - Glyphs 4-7 are the icons in icon-index order.
  - Each glyph has at least one nonzero row; no two glyphs are identical.
- Display content:
  - At entry to LINE1, select_figures and sleep are latched into snapshot registers. Both lines use only the snapshot, so input changes during a draw take effect on the next redraw.
  - Every column other than FACE_COL is 8'h20 (space).
  - Line 1 at FACE_COL: face index (codes 8'h00-8'h03). In sleep view it is 8'h7A ('z') instead.
  - Line 2 at FACE_COL: 8'h04 + icon index. In sleep view it is 8'h20.
- WAIT loop:
  - Each cycle, compare the live select_figures and sleep with the snapshot.
  - On any difference, go to LINE1, skipping INIT and CGRAM.
  - With no difference, stay in WAIT indefinitely with no enable pulses.
- Sequence totals:
  - From reset: 1 + 4 + 65 + 17 + 17 = 104 steps (103 enable pulses) to reach WAIT.
  - Each redraw: 34 steps.

Optional Feature:
- Macro SLEEP_VIEW_EN.
- Defined: sleep==2'b11 selects the sleep view as described, and a change on sleep triggers a redraw.
- Undefined: the sleep input is ignored entirely. It is excluded from the snapshot and the comparison, and the normal view is always drawn.

Test Plan:
- Reset held 5 cycles, select_figures=4'b1000, sleep=2'b00 (COUNT_MAX=100) -> outputs 0/0/0/8'h00 during reset. After release, the first four enable pulses carry rs=0 with data 38, 0C, 01, 06; then rs=0 data 40; then 64 rs=1 bytes.
- Same run, line 1 -> command 8'h80, then 16 bytes: col 7 = 8'h02, all others 8'h20.
- Same run, line 2 -> command 8'hC0, then col 7 = 8'h04, others 8'h20. Then no further enable pulses for 10*COUNT_MAX cycles.
- In WAIT, change select_figures to 4'b0101 -> redraw starting with command 8'h80 (no 38/40 commands). Line 1 col 7 = 8'h01; line 2 col 7 = 8'h05.
- In WAIT with SLEEP_VIEW_EN defined, set sleep=2'b11 -> line 1 col 7 = 8'h7A and line 2 is all 8'h20. With the macro undefined -> no redraw occurs.
- Assert reset during the line-1 draw -> outputs go to their reset values next cycle, and the sequence restarts with 8'h38 after POWER_WAIT.
